// File: rtl/systolic_drain_unit.sv
// Snapshots a row of systolic node accumulators, clears the nodes, then streams the sums out over valid/ready.
// Define DRAIN_SATURATE_EN to saturate each sum to the signed OUT_N range instead of truncating it.
module systolic_drain_unit #(
   parameter int NODES_N     = 4,
   parameter int ACCUM_OUT_N = 32,
   parameter int OUT_N       = 16,
   localparam int IDX_N      = $clog2(NODES_N)
) (
   input  logic                           Clock,
   input  logic                           Reset,
   input  logic                           Drain_Start,
   input  logic [NODES_N*ACCUM_OUT_N-1:0] Accum_In,
   output logic                           Clear_Out,
   output logic                           Busy,
   output logic                           Out_Valid,
   input  logic                           Out_Ready,
   output logic signed [OUT_N-1:0]        Out_Data,
   output logic [IDX_N-1:0]               Out_Index,
   output logic                           Out_Last,
   output logic                           Done,
   output logic                           Overrun
);

   typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

   localparam logic [IDX_N-1:0] LAST_IDX = IDX_N'(NODES_N - 1);

   state_t state, state_next;

   logic signed [OUT_N-1:0] buffer  [NODES_N];
   logic signed [OUT_N-1:0] conv_in [NODES_N];

   logic                    capture;
   logic                    clear_next, valid_next, last_next, done_next, overrun_next;
   logic signed [OUT_N-1:0] data_next;
   logic [IDX_N-1:0]        index_next, index_inc;

   // Conversion happens on the way into the buffer, so it only ever holds OUT_N-bit results.
`ifdef DRAIN_SATURATE_EN
   localparam logic signed [ACCUM_OUT_N-1:0] SAT_MAX =
      {{(ACCUM_OUT_N-OUT_N+1){1'b0}}, {(OUT_N-1){1'b1}}};
   localparam logic signed [ACCUM_OUT_N-1:0] SAT_MIN =
      {{(ACCUM_OUT_N-OUT_N+1){1'b1}}, {(OUT_N-1){1'b0}}};

   logic signed [ACCUM_OUT_N-1:0] slice;

   always_comb begin
      slice = '0;
      for (int i = 0; i < NODES_N; i++) begin
         slice = Accum_In[i*ACCUM_OUT_N +: ACCUM_OUT_N];
         if (slice > SAT_MAX)
            conv_in[i] = SAT_MAX[OUT_N-1:0];
         else if (slice < SAT_MIN)
            conv_in[i] = SAT_MIN[OUT_N-1:0];
         else
            conv_in[i] = slice[OUT_N-1:0];
      end
   end
`else
   logic unused_accum_bits;
   assign unused_accum_bits = ^Accum_In;

   always_comb begin
      for (int i = 0; i < NODES_N; i++)
         conv_in[i] = Accum_In[i*ACCUM_OUT_N +: OUT_N];
   end
`endif

   assign Busy      = (state != IDLE);
   assign index_inc = Out_Index + IDX_N'(1);

   always_comb begin
      state_next   = state;
      capture      = 1'b0;
      clear_next   = 1'b0;
      valid_next   = Out_Valid;
      last_next    = Out_Last;
      done_next    = 1'b0;
      overrun_next = 1'b0;
      data_next    = Out_Data;
      index_next   = Out_Index;
      case (state)
         IDLE: begin
            if (Drain_Start) begin
               capture    = 1'b1;
               clear_next = 1'b1;
               valid_next = 1'b1;
               data_next  = conv_in[0];
               index_next = '0;
               last_next  = 1'b0;
               state_next = STREAM;
            end
         end
         STREAM: begin
            overrun_next = Drain_Start;
            if (Out_Valid && Out_Ready) begin
               if (Out_Index == LAST_IDX) begin
                  valid_next = 1'b0;
                  last_next  = 1'b0;
                  data_next  = '0;
                  index_next = '0;
                  done_next  = 1'b1;
                  state_next = FINISH;
               end else begin
                  data_next  = buffer[index_inc];
                  index_next = index_inc;
                  last_next  = (index_inc == LAST_IDX);
               end
            end
         end
         FINISH: begin
            overrun_next = Drain_Start;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Every output is a flop; reset abandons any drain in progress without a Done.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         Clear_Out <= 1'b0;
         Out_Valid <= 1'b0;
         Out_Last  <= 1'b0;
         Done      <= 1'b0;
         Overrun   <= 1'b0;
         Out_Data  <= '0;
         Out_Index <= '0;
         for (int i = 0; i < NODES_N; i++)
            buffer[i] <= '0;
      end else begin
         state     <= state_next;
         Clear_Out <= clear_next;
         Out_Valid <= valid_next;
         Out_Last  <= last_next;
         Done      <= done_next;
         Overrun   <= overrun_next;
         Out_Data  <= data_next;
         Out_Index <= index_next;
         if (capture) begin
            for (int i = 0; i < NODES_N; i++)
               buffer[i] <= conv_in[i];
         end
      end
   end

endmodule

// File: tb/tb_systolic_drain_unit.sv
// Self-checking bench for systolic_drain_unit: queue-based reference model, per-cycle compare, directed and random stimulus.
// Build with or without DRAIN_SATURATE_EN to match the DUT.
module tb_systolic_drain_unit;

   localparam int NODES_N     = 4;
   localparam int ACCUM_OUT_N = 32;
   localparam int OUT_N       = 16;
   localparam int IDX_N       = $clog2(NODES_N);

   logic                           Clock;
   logic                           Reset;
   logic                           Drain_Start;
   logic [NODES_N*ACCUM_OUT_N-1:0] Accum_In;
   logic                           Clear_Out;
   logic                           Busy;
   logic                           Out_Valid;
   logic                           Out_Ready;
   logic signed [OUT_N-1:0]        Out_Data;
   logic [IDX_N-1:0]               Out_Index;
   logic                           Out_Last;
   logic                           Done;
   logic                           Overrun;

   systolic_drain_unit #(
      .NODES_N    (NODES_N),
      .ACCUM_OUT_N(ACCUM_OUT_N),
      .OUT_N      (OUT_N)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Drain_Start(Drain_Start),
      .Accum_In   (Accum_In),
      .Clear_Out  (Clear_Out),
      .Busy       (Busy),
      .Out_Valid  (Out_Valid),
      .Out_Ready  (Out_Ready),
      .Out_Data   (Out_Data),
      .Out_Index  (Out_Index),
      .Out_Last   (Out_Last),
      .Done       (Done),
      .Overrun    (Overrun)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   int got_data[$];
   int got_idx[$];
   int clear_cnt, done_cnt, overrun_cnt;

   int snap[$];
   bit in_finish;
   bit exp_busy, exp_valid, exp_last, exp_clear, exp_done, exp_overrun;
   int exp_data, exp_index;

   function automatic int conv(input longint v);
      longint t;
`ifdef DRAIN_SATURATE_EN
      longint hi = (longint'(1) << (OUT_N - 1)) - 1;
      longint lo = -hi - 1;
      if (v > hi)      t = hi;
      else if (v < lo) t = lo;
      else             t = v;
`else
      longint m = longint'(1) << OUT_N;
      t = v % m;
      if (t < 0) t += m;
      if (t >= m / 2) t -= m;
`endif
      return int'(t);
   endfunction

   function automatic logic [NODES_N*ACCUM_OUT_N-1:0] pack4(input int n0, input int n1, input int n2, input int n3);
      return {n3, n2, n1, n0};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, $signed(act), $signed(exp), $time);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic ds, input logic rdy);
      @(posedge Clock);
      #2;
      Reset       = rst;
      Drain_Start = ds;
      Out_Ready   = rdy;
   endtask

   // Reference model: a drain is just the list of converted snapshot values, popped on each accepted transfer.
   always @(posedge Clock) begin
      bit was_busy;
      if (Reset) begin
         snap.delete();
         in_finish   = 1'b0;
         exp_clear   = 1'b0;
         exp_done    = 1'b0;
         exp_overrun = 1'b0;
      end else begin
         was_busy    = (snap.size() != 0) || in_finish;
         exp_overrun = Drain_Start && was_busy;
         exp_clear   = 1'b0;
         exp_done    = 1'b0;
         in_finish   = 1'b0;
         if (!was_busy && Drain_Start) begin
            for (int i = 0; i < NODES_N; i++)
               snap.push_back(conv(longint'($signed(Accum_In[i*ACCUM_OUT_N +: ACCUM_OUT_N]))));
            exp_clear = 1'b1;
         end else if (snap.size() != 0 && Out_Ready) begin
            snap.delete(0);
            if (snap.size() == 0) begin
               in_finish = 1'b1;
               exp_done  = 1'b1;
            end
         end
      end
      exp_valid = (snap.size() != 0);
      exp_busy  = exp_valid || in_finish;
      exp_data  = exp_valid ? snap[0] : 0;
      exp_index = NODES_N - snap.size();
      exp_last  = (snap.size() == 1);
   end

   always @(negedge Clock) begin
      if (check_en) begin
         checkOutput("busy", Busy, exp_busy);
         checkOutput("clear", Clear_Out, exp_clear);
         checkOutput("valid", Out_Valid, exp_valid);
         checkOutput("last", Out_Last, exp_last);
         checkOutput("done", Done, exp_done);
         checkOutput("overrun", Overrun, exp_overrun);
         if (exp_valid) begin
            checkOutput("data", Out_Data, exp_data);
            checkOutput("index", Out_Index, exp_index);
         end
         if (Out_Valid === 1'b1 && Out_Ready === 1'b1) begin
            got_data.push_back(int'(Out_Data));
            got_idx.push_back(int'(Out_Index));
         end
         clear_cnt   += int'(Clear_Out === 1'b1);
         done_cnt    += int'(Done === 1'b1);
         overrun_cnt += int'(Overrun === 1'b1);
      end
   end

   task automatic clearTally();
      got_data.delete();
      got_idx.delete();
      clear_cnt   = 0;
      done_cnt    = 0;
      overrun_cnt = 0;
   endtask

   initial begin
      int lit[4];
      int tog[7];
      Reset       = 1'b1;
      Drain_Start = 1'b0;
      Out_Ready   = 1'b0;
      Accum_In    = '0;
      clearTally();

      // The model's conversion pinned to hand-computed values.
`ifdef DRAIN_SATURATE_EN
      checkOutput("model_conv_pos", conv(70000), 32767);
      checkOutput("model_conv_neg", conv(-70000), -32768);
`else
      checkOutput("model_conv_pos", conv(70000), 4464);
      checkOutput("model_conv_neg", conv(-70000), -4464);
`endif

      applyStimulus(1, 0, 0);
      applyStimulus(1, 0, 0);
      check_en = 1'b1;
      repeat (3) applyStimulus(0, 0, 0);
      checkOutput("reset_data", Out_Data, 0);
      checkOutput("reset_index", Out_Index, 0);
      checkOutput("reset_busy", Busy, 0);
      checkOutput("reset_clear_count", clear_cnt, 0);

      // Full-throughput drain; the node inputs are wiped right after the snapshot.
      lit = '{15, 300, -7, 40};
      clearTally();
      Accum_In = pack4(15, 300, -7, 40);
      applyStimulus(0, 1, 1);
      applyStimulus(0, 0, 1);
      Accum_In = '0;
      repeat (6) applyStimulus(0, 0, 1);
      checkOutput("full_xfer_count", got_data.size(), 4);
      for (int i = 0; i < got_data.size() && i < 4; i++) begin
         checkOutput("full_data", got_data[i], lit[i]);
         checkOutput("full_index", got_idx[i], i);
      end
      checkOutput("full_clear_count", clear_cnt, 1);
      checkOutput("full_done_count", done_cnt, 1);

      // Back-pressure pattern on Out_Ready.
      tog = '{1, 0, 0, 1, 0, 1, 1};
      clearTally();
      Accum_In = pack4(15, 300, -7, 40);
      applyStimulus(0, 1, 0);
      for (int i = 0; i < 7; i++) applyStimulus(0, 0, tog[i] != 0);
      repeat (3) applyStimulus(0, 0, 0);
      checkOutput("stall_xfer_count", got_data.size(), 4);
      for (int i = 0; i < got_data.size() && i < 4; i++) begin
         checkOutput("stall_data", got_data[i], lit[i]);
         checkOutput("stall_index", got_idx[i], i);
      end
      checkOutput("stall_done_count", done_cnt, 1);

      // Mid-stream Drain_Start, then reset while element 2 is presented.
      clearTally();
      applyStimulus(0, 1, 0);
      applyStimulus(0, 0, 1);
      applyStimulus(0, 1, 1);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      checkOutput("abort_valid", Out_Valid, 0);
      checkOutput("abort_busy", Busy, 0);
      repeat (3) applyStimulus(0, 0, 1);
      checkOutput("abort_overrun_count", overrun_cnt, 1);
      checkOutput("abort_clear_count", clear_cnt, 1);
      checkOutput("abort_done_count", done_cnt, 0);
      checkOutput("abort_xfer_count", got_data.size(), 2);

      // Conversion boundaries.
      clearTally();
      Accum_In = pack4(70000, -70000, 32767, -32768);
      applyStimulus(0, 1, 1);
      repeat (7) applyStimulus(0, 0, 1);
`ifdef DRAIN_SATURATE_EN
      lit = '{32767, -32768, 32767, -32768};
`else
      lit = '{4464, -4464, 32767, -32768};
`endif
      checkOutput("conv_xfer_count", got_data.size(), 4);
      for (int i = 0; i < got_data.size() && i < 4; i++)
         checkOutput("conv_data", got_data[i], lit[i]);

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int n = 0; n < NODES_N; n++) begin
               case ($urandom_range(0, 3))
                  0:       Accum_In[n*ACCUM_OUT_N +: ACCUM_OUT_N] = $urandom;
                  1:       Accum_In[n*ACCUM_OUT_N +: ACCUM_OUT_N] = 32'($urandom_range(0, 65535)) - 32'd32768;
                  2:       Accum_In[n*ACCUM_OUT_N +: ACCUM_OUT_N] = 32'($urandom_range(0, 4)) + 32'd32766;
                  default: Accum_In[n*ACCUM_OUT_N +: ACCUM_OUT_N] = 32'hFFFF_8000 - 32'($urandom_range(0, 4));
               endcase
            end
         end
         applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
      end
      repeat (8) applyStimulus(0, 0, 1);

      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/systolic_drain_unit.md
Name: systolic_drain_unit

Overview:
Output stage directly downstream of a row of systolic MAC nodes. On command it snapshots every node's Accum_Out into a shadow buffer and pulses Clear back to the nodes, so the array can start the next tile immediately. It then streams the captured sums one per handshake over a valid/ready interface to the writeback path.

Parameters:
NODES_N, 4, number of nodes drained (one accumulator per node); legal range >= 2
ACCUM_OUT_N, 32, width of each node accumulator (signed)
OUT_N, 16, width of streamed result (signed); OUT_N <= ACCUM_OUT_N
IDX_N, $clog2(NODES_N), width of Out_Index (derived localparam, not overridable)

Ports:
Clock  in  1  single clock domain, all logic on posedge
Reset  in  1  synchronous, active-high
Drain_Start  in  1  single-cycle request to snapshot and drain
Accum_In  in  NODES_N*ACCUM_OUT_N  packed node accumulators; node i occupies bits [i*ACCUM_OUT_N +: ACCUM_OUT_N]
Clear_Out  out  1  to every node's Clear input
Busy  out  1  high in any state other than IDLE
Out_Valid  out  1  result-stream valid
Out_Ready  in  1  result-stream ready from consumer
Out_Data  out  OUT_N  signed result
Out_Index  out  IDX_N  node index of Out_Data
Out_Last  out  1  marks final element (index NODES_N-1)
Done  out  1  one-cycle pulse after final handshake
Overrun  out  1  one-cycle pulse when Drain_Start is ignored

Behaviour:
- Reset (synchronous, active-high): state IDLE; Clear_Out, Busy, Out_Valid, Out_Last, Done and Overrun are 0; Out_Data and Out_Index are 0; shadow buffer cleared to 0. Reset asserted mid-stream abandons the drain immediately, and no Done is issued.
- States are IDLE, STREAM and FINISH. All outputs are registered.
- IDLE, with Drain_Start=1 at edge k:
  - capture all NODES_N slices of Accum_In into the buffer at edge k;
  - Clear_Out=1 during the cycle after k only (exactly one cycle);
  - state becomes STREAM, index 0.
- Upstream sequencing rule: the upstream controller must not assert Drain_Start until at least 2 cycles after the last valid activation/weight pair. The node has a one-cycle product pipeline, so the final product lands one edge late. This unit does not check the rule.
- STREAM:
  - Out_Valid=1 from the cycle after k; Out_Data holds the converted buffer[index]; Out_Index = index.
  - Out_Last = (index == NODES_N-1).
  - On an edge with Out_Valid && Out_Ready: if index < NODES_N-1, index increments and the next element appears in the following cycle. If index == NODES_N-1, state goes to FINISH and Out_Valid drops.
  - While Out_Ready=0: Out_Data, Out_Index and Out_Last hold stable, and Out_Valid stays 1 (never retracted).
  - Full throughput: with Out_Ready held high, NODES_N elements take NODES_N consecutive cycles.
- FINISH: Done=1 for one cycle, then return to IDLE. A Drain_Start present in FINISH is ignored (Overrun).
- Drain_Start while Busy: ignored, with Overrun=1 during the next cycle. The buffer and stream are unaffected, and no extra Clear_Out is issued.
- Conversion ACCUM_OUT_N to OUT_N: default truncation keeps bits [OUT_N-1:0]; see Optional Feature. When OUT_N == ACCUM_OUT_N the value passes through unchanged.
- Node accumulators may change after capture (they are cleared and restart); the stream always reflects the snapshot.
- Latency: Drain_Start edge to first Out_Valid is 1 cycle. Last handshake to Done is 1 cycle. Best-case Drain_Start to Done is NODES_N+1 cycles.

Optional Feature:
- Macro: DRAIN_SATURATE_EN.
- Defined: each value is saturated to the signed OUT_N range. Values above 2^(OUT_N-1)-1 clamp to max; values below -2^(OUT_N-1) clamp to min. Conversion is done at capture, so the buffer stores OUT_N-bit values.
- Not defined: plain truncation to the low OUT_N bits, with no clamping logic present.

Test Plan:
- Reset, then idle 3 cycles -> all outputs 0, Busy=0, no Clear_Out.
- Accum_In = {40,-7,300,15} (node3..node0); pulse Drain_Start; Out_Ready=1 -> Clear_Out 1 cycle. Stream 15,300,-7,40 on 4 consecutive cycles with Out_Index 0..3. Out_Last only on index 3. Done exactly 1 cycle after the last handshake.
- Same stream, Out_Ready toggled 1,0,0,1,0,1,1 -> each element held stable while stalled; exactly 4 transfers, no duplicates or skips.
- Change Accum_In to all zeros the cycle after Drain_Start -> streamed values still 15,300,-7,40.
- Drain_Start pulsed mid-stream -> Overrun 1 cycle, stream unchanged, no second Clear_Out; Reset asserted at index 2 -> next cycle IDLE, Out_Valid=0, no Done.
- Accum_In node0=70000, node1=-70000, OUT_N=16 -> with DRAIN_SATURATE_EN: 32767, -32768; without it: 4464, -4464.
